mipszy_mem_loader: RTL and testbench
====================================

// Module: mipszy_mem_loader
// PURPOSE
//  Front-door writer for the MIPSzy instruction and data memories; the write-side counterpart of the debug read port.
//  Accepts a stream of 32-bit words over a valid/ready handshake and writes them to consecutive word addresses of IM or DM.
//  Holds the CPU in reset (cpu_hold) for the whole load, so programs and test data load through RTL, not hierarchical pokes.
//  Sits between the host/bench stream source and the write ports of IM and DM, alongside the MIPSzy core.
// PARAMETERS
//  ADDR_W  10      word-address width of IM/DM (1024 words); DM word addr = (byte_addr-4096)/4
//  DATA_W  32      data word width
//  CNT_W   11      transfer-count width (ADDR_W+1, so 1024 words fits)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin a load; sampled only in IDLE
//  sel        in   1       0 = IM, 1 = DM; latched on start
//  base_addr  in   ADDR_W  first word address; latched on start
//  count      in   CNT_W   number of words to load; latched on start
//  abort      in   1       cancel the load in progress
//  in_valid   in   1       in_data valid
//  in_data    in   DATA_W  word to write
//  in_ready   out  1       loader accepts in_data this cycle
//  mem_we     out  1       write strobe (one cycle per word)
//  mem_sel    out  1       0 = IM write, 1 = DM write (qualifies mem_we)
//  mem_addr   out  ADDR_W  word address of the write
//  mem_wdata  out  DATA_W  write data
//  cpu_hold   out  1       hold the MIPSzy core in reset while high
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse: all words written
//  wrap_err   out  1       sticky: address wrapped past 2^ADDR_W-1; cleared by the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (mem_we, mem_sel, mem_addr, mem_wdata, in_ready, cpu_hold, busy, done, wrap_err).
//  Reset mid-load: same values next cycle. Words already written stay in memory; the pending registered write is dropped.
//  States:
//   IDLE
//    start=1 & count!=0: latch sel/base_addr/count, go LOAD.
//    start=1 & count==0: stay IDLE, done=1 next cycle, no writes, cpu_hold stays 0.
//   LOAD
//    cpu_hold=1, busy=1, in_ready = !abort.
//    Handshake = in_valid & in_ready.
//   DRAIN
//    One cycle; in_ready=0; last write visible on the memory port; then IDLE.
//  Write timing:
//   Handshake in cycle N -> mem_we=1 with mem_addr/mem_wdata/mem_sel registered in cycle N+1. Latency 1.
//   Back-to-back handshakes give one write per cycle.
//   mem_we=0 in any cycle that follows a cycle with no handshake. mem_addr and mem_wdata hold their last values.
//  Addressing: the address increments by 1 per write, mod 2^ADDR_W. 1023 -> 0 sets wrap_err; the load continues.
//  Completion:
//   The handshake that takes remaining from 1 to 0 (cycle N) moves to DRAIN at N+1.
//   At N+2: IDLE, done=1, cpu_hold=0, busy=0.
//  Abort in LOAD: in_ready=0 that cycle, so no handshake. A write registered in the prior cycle still completes.
//   Next cycle: IDLE, cpu_hold=0, done stays 0.
//  Abort in DRAIN: ignored; done still pulses.
//  start outside IDLE: ignored; latched parameters unchanged.
//  in_valid outside LOAD: ignored, no writes.
//  Remaining-word counter is CNT_W bits. count is never exceeded: in_ready drops once remaining reaches 0.
// TESTING
//  1. IM load: sel=0, base=0, count=32, in_valid held 1.
//     -> 32 consecutive mem_we, addr 0..31, data in order.
//     -> done at cycle 34 after start; cpu_hold high throughout, low with done.
//  2. DM load: sel=1, base=226, count=8, data 10,5,2,0,9,7,0,2.
//     -> writes addr 226..233 with those values; debug reads of addr 226..233 return the same after run.
//  3. Backpressure: count=4, in_valid pattern 1,0,0,1,1,0,1.
//     -> exactly 4 writes, each one cycle after its handshake, addresses contiguous; done once.
//  4. Wrap: base=1022, count=4.
//     -> writes at 1022,1023,0,1; wrap_err=1 after the 1023->0 step; cleared by next start.
//  5. count=0 start -> done pulse next cycle, no mem_we, cpu_hold never high.
//     start asserted during LOAD -> ignored.
//  6. Abort after 3 of 8 words -> exactly 3 writes, no done, cpu_hold=0 next cycle.
//     rst after 5 of 8 words -> all outputs 0 next cycle, no 6th write.

Source files
------------

// File: rtl/mipszy_mem_loader_if.sv
// Bundle of the loader's control, input stream and memory write-port signals.
// The host/bench side uses the master modport; the loader uses the slave modport.
interface mipszy_mem_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 11
);
    logic              start;
    logic              sel;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              wrap_err;

    modport master (
        output start, sel, base_addr, count, abort, in_valid, in_data,
        input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata,
        input  cpu_hold, busy, done, wrap_err
    );

    modport slave (
        input  start, sel, base_addr, count, abort, in_valid, in_data,
        output in_ready, mem_we, mem_sel, mem_addr, mem_wdata,
        output cpu_hold, busy, done, wrap_err
    );
endinterface

// File: rtl/mipszy_mem_loader.sv
// Streams words into consecutive IM/DM word addresses while holding the MIPSzy core
// in reset; one registered write per accepted word.
module mipszy_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 11
) (
    input  logic               clk,
    input  logic               rst,
    mipszy_mem_loader_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_reg,     state_next;
    logic              sel_reg,       sel_next;
    logic [ADDR_W-1:0] addr_reg,      addr_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic              mem_we_reg,    mem_we_next;
    logic              mem_sel_reg,   mem_sel_next;
    logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              done_reg,      done_next;
    logic              wrap_err_reg,  wrap_err_next;

    logic in_ready_w;
    logic handshake;

    // Abort blocks the handshake in the same cycle, so no word is taken while cancelling.
    assign in_ready_w = (state_reg == ST_LOAD) && !bus.abort && (remaining_reg != '0);
    assign handshake  = bus.in_valid && in_ready_w;

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        mem_we_next    = handshake;
        mem_sel_next   = mem_sel_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        done_next      = 1'b0;
        wrap_err_next  = wrap_err_reg;

        if (handshake) begin
            mem_sel_next   = sel_reg;
            mem_addr_next  = addr_reg;
            mem_wdata_next = bus.in_data;
            addr_next      = addr_reg + ADDR_W'(1);
            remaining_next = remaining_reg - CNT_W'(1);
            // Writing the top word means the pointer rolls over to 0.
            if (addr_reg == '1) begin
                wrap_err_next = 1'b1;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    wrap_err_next = 1'b0;
                    if (bus.count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        sel_next       = bus.sel;
                        addr_next      = bus.base_addr;
                        remaining_next = bus.count;
                        state_next     = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (handshake && (remaining_reg == CNT_W'(1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            sel_reg       <= 1'b0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            mem_we_reg    <= 1'b0;
            mem_sel_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            done_reg      <= 1'b0;
            wrap_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            mem_we_reg    <= mem_we_next;
            mem_sel_reg   <= mem_sel_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            done_reg      <= done_next;
            wrap_err_reg  <= wrap_err_next;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_sel   = mem_sel_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.cpu_hold  = (state_reg != ST_IDLE);
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.done      = done_reg;
    assign bus.wrap_err  = wrap_err_reg;
endmodule

// File: tb/tb_mipszy_mem_loader.sv
// Scoreboard bench for mipszy_mem_loader: each load pushes its expected writes, a
// negedge monitor pops them as mem_we appears and checks handshake-to-write latency.
module tb_mipszy_mem_loader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 11;

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] feed_q[$];
    logic [DATA_W-1:0] exp_im[1024];
    logic [DATA_W-1:0] exp_dm[1024];
    logic [DATA_W-1:0] obs_im[1024];
    logic [DATA_W-1:0] obs_dm[1024];

    int   hs_total = 0;
    int   done_total = 0;
    int   hold_total = 0;
    int   last_done_cyc = -1;
    logic mon_hs_prev;
    logic mon_rst_prev;
    wr_t  mon_e;

    mipszy_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    mipszy_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, bus.in_ready,
                    bus.cpu_hold, bus.busy, bus.done, bus.wrap_err});
    endfunction

    // Monitor: every mem_we must follow a handshake (not cancelled by reset) by one cycle.
    initial begin
        mon_hs_prev  = 1'b0;
        mon_rst_prev = 1'b1;
        forever begin
            @(negedge clk);
            chk("mem_we_latency", 64'(bus.mem_we), 64'(mon_hs_prev && !mon_rst_prev));
            if (bus.mem_we) begin
                $display("write %s addr=%0d data=0x%08h", bus.mem_sel ? "DM" : "IM",
                         bus.mem_addr, bus.mem_wdata);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(bus.mem_addr), 64'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_sel_addr_data", 64'({bus.mem_sel, bus.mem_addr, bus.mem_wdata}),
                        64'(mon_e));
                end
                if (bus.mem_sel) obs_dm[bus.mem_addr] = bus.mem_wdata;
                else             obs_im[bus.mem_addr] = bus.mem_wdata;
            end
            if (bus.done) begin
                done_total++;
                last_done_cyc = cyc;
                chk("hold_low_at_done", 64'({bus.cpu_hold, bus.busy}), 64'(0));
            end
            if (bus.cpu_hold) hold_total++;
            mon_hs_prev  = bus.in_valid && bus.in_ready;
            mon_rst_prev = rst;
            if (mon_hs_prev) hs_total++;
        end
    end

    // mode: 0 = in_valid always 1, 1 = random, 2 = fixed 1,0,0,1,1,0,1 pattern.
    // stop_kind: 0 = run to completion, 1 = abort after stop_after words, 2 = rst after stop_after.
    task automatic do_load(input logic s, input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n,
                           input int mode, input int stop_kind, input int stop_after, input bit poke);
        logic [DATA_W-1:0] words[$];
        logic [ADDR_W-1:0] a;
        bit pat[7];
        int nint, nexp, idx, pat_i, budget, start_cyc, hs0, done0, hold0;
        bit stop, acc, v;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        nint = int'(n);
        words = feed_q;
        feed_q.delete();
        while (words.size() < nint) words.push_back($urandom);
        nexp = (stop_kind != 0) ? stop_after : nint;
        $display("load sel=%0d base=%0d count=%0d mode=%0d stop=%0d@%0d", s, b, n, mode,
                 stop_kind, stop_after);
        for (int i = 0; i < nexp; i++) begin
            a = b + ADDR_W'(i);
            exp_q.push_back('{s, a, words[i]});
            if (s) exp_dm[a] = words[i];
            else   exp_im[a] = words[i];
        end

        // Stray in_valid while idle must not write anything.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        hs0 = hs_total; done0 = done_total; hold0 = hold_total;
        bus.start = 1'b1; bus.sel = s; bus.base_addr = b; bus.count = n;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.sel = ~s;
        bus.base_addr = ADDR_W'($urandom); bus.count = CNT_W'($urandom);

        idx = 0; pat_i = 0; budget = 0;
        stop = (nint == 0);
        while (!stop && budget < 3000) begin
            if (stop_kind != 0 && idx == stop_after) begin
                if (stop_kind == 1) bus.abort = 1'b1;
                else                rst = 1'b1;
                bus.in_valid = 1'b1;
                bus.in_data  = words[idx];
                @(posedge clk);
                #1;
                bus.abort = 1'b0; rst = 1'b0; bus.in_valid = 1'b0;
                stop = 1'b1;
                @(negedge clk);
                if (stop_kind == 1) chk("abort_release", 64'({bus.cpu_hold, bus.busy, bus.in_ready}), 64'(0));
                else                chk("reset_midload", all_outs(), 64'(0));
            end else begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = 1'($urandom_range(0, 1));
                    default: v = pat[pat_i % 7];
                endcase
                bus.in_valid = (idx < nint) && v;
                bus.in_data  = (idx < nint) ? words[idx] : $urandom;
                if (poke && budget == 3) begin
                    bus.start = 1'b1; bus.sel = ~s;
                    bus.base_addr = ADDR_W'($urandom); bus.count = CNT_W'(5);
                end
                @(negedge clk);
                acc = bus.in_valid && bus.in_ready;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                if (acc) idx++;
                pat_i++;
                budget++;
                if (idx == nint) stop = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (stop_kind == 0) begin
            while (done_total == done0 && budget < 3000) begin
                @(posedge clk);
                #1;
                budget++;
            end
        end
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        chk("done_count", 64'(done_total - done0), 64'((stop_kind == 0) ? 1 : 0));
        if (stop_kind != 2) chk("handshake_count", 64'(hs_total - hs0), 64'(nexp));
        if (stop_kind == 0 && mode == 0) begin
            chk("done_latency", 64'(last_done_cyc - start_cyc), 64'((nint == 0) ? 1 : nint + 2));
            chk("hold_cycles", 64'(hold_total - hold0), 64'((nint == 0) ? 0 : nint + 1));
        end
        if (stop_kind != 2 && (int'(b) + nexp) != 1024)
            chk("wrap_err", 64'(bus.wrap_err), 64'((int'(b) + nexp) > 1024));
    endtask

    initial begin
        int bad;
        logic              rs;
        logic [ADDR_W-1:0] rb;
        logic [CNT_W-1:0]  rn;
        bus.start = 1'b0; bus.sel = 1'b0; bus.base_addr = '0; bus.count = '0;
        bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        for (int i = 0; i < 1024; i++) begin
            exp_im[i] = '0; exp_dm[i] = '0; obs_im[i] = '0; obs_dm[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_load(1'b0, 10'd0, 11'd32, 0, 0, 0, 1'b0);

        feed_q = '{32'd10, 32'd5, 32'd2, 32'd0, 32'd9, 32'd7, 32'd0, 32'd2};
        do_load(1'b1, 10'd226, 11'd8, 0, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) chk("dm_readback", 64'(obs_dm[226 + i]), 64'(exp_dm[226 + i]));

        do_load(1'b0, 10'd700, 11'd4, 2, 0, 0, 1'b0);
        do_load(1'b1, 10'd1022, 11'd4, 1, 0, 0, 1'b0);
        do_load(1'b0, 10'd100, 11'd3, 0, 0, 0, 1'b0);
        do_load(1'b1, 10'd50, 11'd0, 0, 0, 0, 1'b0);
        do_load(1'b0, 10'd300, 11'd10, 1, 0, 0, 1'b1);
        do_load(1'b0, 10'd500, 11'd8, 0, 1, 3, 1'b0);
        do_load(1'b1, 10'd600, 11'd8, 0, 2, 5, 1'b0);

        for (int k = 0; k < 6; k++) begin
            rs = 1'($urandom_range(0, 1));
            rb = ADDR_W'($urandom_range(0, 1023));
            rn = CNT_W'($urandom_range(1, 40));
            if (int'(rb) + int'(rn) == 1024) rn = rn + CNT_W'(1);
            do_load(rs, rb, rn, 1, 0, 0, 1'b0);
        end

        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (exp_im[i] !== obs_im[i]) bad++;
            if (exp_dm[i] !== obs_dm[i]) bad++;
        end
        chk("memory_image", 64'(bad), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
